// File: rtl/shifter_arbiter_if.sv
// Bundle shared by shifter_arbiter: requester handshakes, the external Shifter hookup and the
// registered result port. The arbiter connects as slave; requesters, Shifter and consumer as master.
interface shifter_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_in1;
  logic [NREQ*5-1:0]  req_shamt;
  logic [NREQ*2-1:0]  req_sel;

  logic [31:0]        sh_in1;
  logic [4:0]         sh_shamt;
  logic [1:0]         sh_select;
  logic [31:0]        sh_result;

  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_result;
  logic [IDW-1:0]     out_tag;

  modport master (
    output req_valid, req_in1, req_shamt, req_sel, sh_result, out_ready,
    input  req_ready, sh_in1, sh_shamt, sh_select, out_valid, out_result, out_tag
  );

  modport slave (
    input  req_valid, req_in1, req_shamt, req_sel, sh_result, out_ready,
    output req_ready, sh_in1, sh_shamt, sh_select, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one combinational Shifter between NREQ requesters; the shift
// result is captured in a one-deep output register (1-cycle latency, 1 result per clock).
module shifter_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic            clk,
  input logic            rst,
  shifter_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StFull} state_e;

  state_e         r_state;
  state_e         w_state_next;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] w_rr_next;
  logic [31:0]    r_result;
  logic [IDW-1:0] r_tag;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gidx;
  logic            w_found;
  int unsigned     w_idx;
  logic            w_accept_ok;
  logic            w_xfer;

  // Rotating priority search: first valid requester at or after r_rr_ptr wins.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_rr_ptr) + k) % NREQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gidx         = IDW'(w_idx);
      end
    end
  end

  assign w_accept_ok   = (r_state == StIdle) | bus.out_ready;
  assign bus.req_ready = rst ? '0 : (w_grant & {NREQ{w_accept_ok}});
  assign w_xfer        = w_found & w_accept_ok & ~rst;
  assign w_rr_next     = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);

  // Idle operands are zero so the Shifter sees select 0 and returns 0.
  always_comb begin
    bus.sh_in1    = '0;
    bus.sh_shamt  = '0;
    bus.sh_select = '0;
    if (w_found) begin
      bus.sh_in1    = bus.req_in1[32*w_gidx +: 32];
      bus.sh_shamt  = bus.req_shamt[5*w_gidx +: 5];
      bus.sh_select = bus.req_sel[2*w_gidx +: 2];
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_xfer) w_state_next = StFull;
      StFull: begin
        if (w_xfer) begin
          w_state_next = StFull;
        end else if (bus.out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_rr_ptr <= '0;
      r_result <= '0;
      r_tag    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer) begin
        r_result <= bus.sh_result;
        r_tag    <= w_gidx;
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  assign bus.out_valid  = (r_state == StFull);
  assign bus.out_result = r_result;
  assign bus.out_tag    = r_tag;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: expected results are queued as requests are issued and a
// monitor pops and compares them whenever the output handshake completes.
module tb_shifter_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;

  logic clk;
  logic rst;

  shifter_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  shifter_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Shifter: 1=sll 2=srl 3=sra 0=null
  always_comb begin
    case (bus.sh_select)
      2'd1:    bus.sh_result = bus.sh_in1 << bus.sh_shamt;
      2'd2:    bus.sh_result = bus.sh_in1 >> bus.sh_shamt;
      2'd3:    bus.sh_result = $unsigned($signed(bus.sh_in1) >>> bus.sh_shamt);
      default: bus.sh_result = 32'h0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]    exp_res[$];
  logic [IDW-1:0] exp_tag[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [IDW-1:0] tag, input logic [31:0] res);
    exp_tag.push_back(tag);
    exp_res.push_back(res);
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] in1,
                         input logic [4:0] shamt, input logic [1:0] sel);
    bus.req_valid[i]         = v;
    bus.req_in1[32*i +: 32]  = in1;
    bus.req_shamt[5*i +: 5]  = shamt;
    bus.req_sel[2*i +: 2]    = sel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a result is consumed on the posedge after this negedge
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_res.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got tag %0d result %h expected none",
                 bus.out_tag, bus.out_result);
      end else begin
        chk("out_tag", 32'(bus.out_tag), 32'(exp_tag.pop_front()));
        chk("out_result", bus.out_result, exp_res.pop_front());
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_in1   = '0;
    bus.req_shamt = '0;
    bus.req_sel   = '0;
    bus.out_ready = 1'b1;

    // 1: reset with both requesters valid
    set_req(0, 1'b1, 32'h0000_0001, 5'd4, 2'd1);
    set_req(1, 1'b1, 32'h8000_0000, 5'd31, 2'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_result", bus.out_result, 32'h0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant", 32'(bus.req_ready), 32'h1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'h0);

    // 2: req0 sll 1<<4
    push_exp(1'b0, 32'h0000_0010);
    step();
    chk("out_valid_after_xfer", 32'(bus.out_valid), 32'h1);

    // 3: req1 sra then srl of 0x8000_0000 by 31
    set_req(0, 1'b0, 32'h0, 5'd0, 2'd0);
    push_exp(1'b1, 32'hFFFF_FFFF);
    step();
    set_req(1, 1'b1, 32'h8000_0000, 5'd31, 2'd2);
    push_exp(1'b1, 32'h0000_0001);
    step();
    set_req(1, 1'b0, 32'h0, 5'd0, 2'd0);
    step();
    step();
    chk("drained_out_valid", 32'(bus.out_valid), 32'h0);

    // 4: both continuously valid -> alternating grants
    set_req(0, 1'b1, 32'h0000_0003, 5'd1, 2'd1);
    set_req(1, 1'b1, 32'h0000_00F0, 5'd4, 2'd2);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(1'b0, 32'h0000_0006);
      else            push_exp(1'b1, 32'h0000_000F);
      @(negedge clk);
      chk("rr_req_ready", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
    end
    set_req(0, 1'b0, 32'h0, 5'd0, 2'd0);
    set_req(1, 1'b0, 32'h0, 5'd0, 2'd0);
    step();
    step();

    // 5: stall while FULL, pending request accepted on the release cycle
    bus.out_ready = 1'b0;
    set_req(0, 1'b1, 32'h0000_00A5, 5'd8, 2'd1);
    push_exp(1'b0, 32'h0000_A500);
    step();
    set_req(0, 1'b0, 32'h0, 5'd0, 2'd0);
    set_req(1, 1'b1, 32'h8000_00F0, 5'd4, 2'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'h1);
      chk("stall_out_result", bus.out_result, 32'h0000_A500);
      chk("stall_out_tag", 32'(bus.out_tag), 32'h0);
      chk("stall_req_ready", 32'(bus.req_ready), 32'h0);
      step();
    end
    bus.out_ready = 1'b1;
    push_exp(1'b1, 32'hF800_000F);
    @(negedge clk);
    chk("release_req_ready", 32'(bus.req_ready), 32'h2);
    step();
    set_req(1, 1'b0, 32'h0, 5'd0, 2'd0);
    step();
    step();

    // 6: reset while FULL drops the result and restores rr_ptr to 0
    bus.out_ready = 1'b0;
    set_req(0, 1'b1, 32'h0000_0001, 5'd1, 2'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_full_req_ready", 32'(bus.req_ready), 32'h0);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    set_req(0, 1'b1, 32'hDEAD_BEEF, 5'd3, 2'd0);
    set_req(1, 1'b1, 32'h0000_0001, 5'd31, 2'd1);
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
    push_exp(1'b0, 32'h0000_0000);
    push_exp(1'b1, 32'h8000_0000);
    step();
    set_req(0, 1'b0, 32'h0, 5'd0, 2'd0);
    @(negedge clk);
    chk("null_sel_out_valid", 32'(bus.out_valid), 32'h1);
    step();
    set_req(1, 1'b0, 32'h0, 5'd0, 2'd0);
    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_res.size()), 32'h0);
    chk("final_out_valid", 32'(bus.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
